alu_pipe_nbit: RTL and testbench

Parametrised N-bit ALU with a registered, flow-controlled output. It adds a valid/ready handshake on input and output, status flags, an accumulator mode and an iterative shift-add multiply. It sits between the operand/decode logic and the writeback register, and it replaces the plain ALU-plus-output-register arrangement wherever back-pressure or multi-cycle ops are needed.

---
 rtl/alu_pipe_nbit.sv | 187 ++++++++++++++++++
 tb/tb_alu_pipe_nbit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_nbit.sv
// N-bit ALU with a registered, valid/ready flow-controlled output, status flags,
// an accumulator operand path and an iterative shift-add multiplier.
module alu_pipe_nbit #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enbl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic [2:0]       ALUOp,
    input  logic             acc_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_WAIT} state_t;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     result_reg, acc_reg;
    logic                 c_out_reg, zero_reg, neg_reg, ovf_reg, out_valid_reg;
    logic [2*WIDTH-1:0]   prod_reg, mcand_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic [CW-1:0]        cnt_reg;

    logic [WIDTH-1:0]     op_a;
    logic                 slot_free, accept, mul_last;
    logic [WIDTH:0]       add_sum, sub_sum;
    logic [WIDTH-1:0]     alu_result;
    logic                 alu_c, alu_v;
    logic [2*WIDTH-1:0]   addend, prod_step;
    logic                 load_en;
    logic [WIDTH-1:0]     load_result;
    logic                 load_c, load_v;

    assign op_a      = acc_sel ? acc_reg : a;
    assign slot_free = !out_valid_reg || out_ready;
    assign in_ready  = enbl && (state_reg == ST_IDLE) && slot_free;
    assign accept    = in_valid && in_ready;
    assign mul_last  = (cnt_reg == CW'(WIDTH - 1));

    // Subtraction as A + ~b + 1, so the carry out is the "no borrow" indication.
    assign add_sum = {1'b0, op_a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
    assign sub_sum = {1'b0, op_a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        alu_result = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (ALUOp)
            OP_AND: alu_result = op_a & b;
            OP_OR:  alu_result = op_a | b;
            OP_XOR: alu_result = op_a ^ b;
            OP_ADD: begin
                alu_result = add_sum[WIDTH-1:0];
                alu_c      = add_sum[WIDTH];
                alu_v      = (op_a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = sub_sum[WIDTH-1:0];
                alu_c      = sub_sum[WIDTH];
                alu_v      = (op_a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SLT: alu_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(b))};
            OP_SLL: alu_result = op_a << b[SW-1:0];
            default: alu_result = '0;
        endcase
    end

    // Multiplicand gated by the current multiplier LSB: one partial product per cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate
    assign prod_step = prod_reg + addend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else if (enbl) begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept && (ALUOp == OP_MUL)) state_next = ST_MUL;
            ST_MUL:  if (mul_last) state_next = slot_free ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (slot_free) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        load_en     = 1'b0;
        load_result = alu_result;
        load_c      = alu_c;
        load_v      = alu_v;
        case (state_reg)
            ST_IDLE: load_en = accept && (ALUOp != OP_MUL);
            ST_MUL: begin
                load_en     = enbl && mul_last && slot_free;
                load_result = prod_step[WIDTH-1:0];
                load_c      = |prod_step[2*WIDTH-1:WIDTH];
                load_v      = 1'b0;
            end
            ST_WAIT: begin
                load_en     = enbl && slot_free;
                load_result = prod_reg[WIDTH-1:0];
                load_c      = |prod_reg[2*WIDTH-1:WIDTH];
                load_v      = 1'b0;
            end
            default: load_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg    <= '0;
            acc_reg       <= '0;
            c_out_reg     <= 1'b0;
            zero_reg      <= 1'b0;
            neg_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            prod_reg      <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            cnt_reg       <= '0;
        end else if (enbl) begin
            if (load_en) begin
                result_reg    <= load_result;
                acc_reg       <= load_result;
                c_out_reg     <= load_c;
                zero_reg      <= (load_result == '0);
                neg_reg       <= load_result[WIDTH-1];
                ovf_reg       <= load_v;
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (accept && (ALUOp == OP_MUL)) begin
                prod_reg   <= '0;
                mcand_reg  <= {{WIDTH{1'b0}}, op_a};
                mplier_reg <= b;
                cnt_reg    <= '0;
            end else if (state_reg == ST_MUL) begin
                prod_reg   <= prod_step;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg + CW'(1);
            end
        end
    end

    assign result    = result_reg;
    assign c_out     = c_out_reg;
    assign zero      = zero_reg;
    assign neg       = neg_reg;
    assign ovf       = ovf_reg;
    assign out_valid = out_valid_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_alu_pipe_nbit.sv
// Self-checking bench for alu_pipe_nbit (WIDTH=8): directed scenarios plus
// randomized ops against an integer-arithmetic reference model.
module tb_alu_pipe_nbit;
    localparam int W = 8;
    localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100, OP_SLT = 3'b101, OP_SLL = 3'b110, OP_MUL = 3'b111;

    logic         clk = 1'b0;
    logic         rst, enbl, c_in, acc_sel, in_valid, in_ready, out_ready;
    logic [W-1:0] a, b, result;
    logic [2:0]   ALUOp;
    logic         c_out, zero, neg, ovf, out_valid, busy;

    int           checks = 0;
    int           failures = 0;
    logic [12:0]  exp_q[$];
    logic [7:0]   model_acc;
    logic [12:0]  dut_vec;

    assign dut_vec = {out_valid, result, c_out, zero, neg, ovf};

    always #5 clk = ~clk;

    alu_pipe_nbit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .enbl(enbl), .a(a), .b(b), .c_in(c_in),
        .ALUOp(ALUOp), .acc_sel(acc_sel), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .c_out(c_out), .zero(zero), .neg(neg), .ovf(ovf),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic void model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                                  input logic ci, output logic [7:0] r, output logic c, output logic v);
        int ux, uy, sx, sy, cv, t, s;
        ux = x; uy = y; sx = $signed(x); sy = $signed(y); cv = ci;
        c = 1'b0; v = 1'b0; t = 0;
        case (op)
            OP_AND: t = ux & uy;
            OP_OR:  t = ux | uy;
            OP_XOR: t = ux ^ uy;
            OP_ADD: begin
                t = ux + uy + cv; c = (t > 255); s = sx + sy + cv; v = (s > 127) || (s < -128);
            end
            OP_SUB: begin
                t = ux - uy; c = (ux >= uy); s = sx - sy; v = (s > 127) || (s < -128);
            end
            OP_SLT: t = (sx < sy) ? 1 : 0;
            OP_SLL: t = ux << (uy % 8);
            default: begin t = ux * uy; c = (t > 255); end
        endcase
        r = t[7:0];
    endfunction

    // Offer one op; returns after the accepting edge (+1). waited = cycles stalled before acceptance.
    task automatic send(input logic [2:0] op, input logic [7:0] aa, input logic [7:0] bb,
                        input logic cc, input logic as, output int waited);
        logic [7:0] opa, r;
        logic c, v, ok;
        ok = 1'b0; waited = 0;
        ALUOp = op; a = aa; b = bb; c_in = cc; acc_sel = as; in_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                opa = as ? model_acc : aa;
                model(op, opa, bb, cc, r, c, v);
                exp_q.push_back({1'b1, r, c, (r == 8'h00), r[7], v});
                model_acc = r;
                waited = i;
                $display("txn op=%0d a=%02h b=%02h cin=%0b acc_sel=%0b opA=%02h exp=%02h", op, aa, bb, cc, as, opa, r);
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL send_accept got=no_accept exp=accept op=%0d", op);
        end
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, dut_vec} !== 14'd0) begin
            failures++; $display("FAIL reset_state got=%h exp=%h", {busy, dut_vec}, 14'd0);
        end
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_add_flags();
        logic [12:0] e; int w;
        send(OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0, w);
        e = exp_q.pop_front();
        e = {1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (dut_vec !== e) begin
            failures++; $display("FAIL add_ff_01 got=%h exp=%h", dut_vec, e);
        end
    endtask

    task automatic test_sub_slt();
        logic [12:0] e; int w;
        send(OP_SUB, 8'h80, 8'h01, 1'b0, 1'b0, w);
        e = exp_q.pop_front();
        e = {1'b1, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1};
        checks++;
        if (dut_vec !== e) begin
            failures++; $display("FAIL sub_80_01 got=%h exp=%h", dut_vec, e);
        end
        send(OP_SUB, 8'h05, 8'h07, 1'b0, 1'b0, w);
        e = exp_q.pop_front();
        e = {1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0};
        checks++;
        if (dut_vec !== e) begin
            failures++; $display("FAIL sub_borrow got=%h exp=%h", dut_vec, e);
        end
        send(OP_SLT, 8'hFE, 8'h01, 1'b0, 1'b0, w);
        e = exp_q.pop_front();
        e = {1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (dut_vec !== e) begin
            failures++; $display("FAIL slt_signed got=%h exp=%h", dut_vec, e);
        end
    endtask

    task automatic test_mul();
        logic [12:0] e; int w, cyc;
        send(OP_MUL, 8'h10, 8'h11, 1'b0, 1'b0, w);
        e = exp_q.pop_front();
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            checks++;
            if ({busy, in_ready} !== 2'b10) begin
                failures++; $display("FAIL mul_busy cyc=%0d got=%b exp=10", cyc, {busy, in_ready});
            end
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (cyc !== 8) begin
            failures++; $display("FAIL mul_latency got=%0d exp=8", cyc);
        end
        e = {1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if ({busy, dut_vec} !== {1'b0, e}) begin
            failures++; $display("FAIL mul_10_11 got=%h exp=%h", {busy, dut_vec}, {1'b0, e});
        end
        send(OP_MUL, 8'h07, 8'h06, 1'b0, 1'b0, w);
        e = exp_q.pop_front();
        wait_out(cyc);
        e = {1'b1, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (dut_vec !== e || cyc !== 8) begin
            failures++; $display("FAIL mul_7_6 got=%h lat=%0d exp=%h lat=8", dut_vec, cyc, e);
        end
    endtask

    task automatic test_back_pressure();
        logic [12:0] e1, e2, e3; int w;
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(OP_ADD, 8'h11, 8'h22, 1'b0, 1'b0, w);
        e1 = exp_q.pop_front();
        ALUOp = OP_ADD; a = 8'h40; b = 8'h05; c_in = 1'b0; acc_sel = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({in_ready, dut_vec} !== {1'b0, e1}) begin
                failures++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i, {in_ready, dut_vec}, {1'b0, e1});
            end
        end
        out_ready = 1'b1;
        send(OP_ADD, 8'h40, 8'h05, 1'b0, 1'b0, w);
        e2 = exp_q.pop_front();
        checks++;
        if (dut_vec !== e2 || w !== 0) begin
            failures++; $display("FAIL bp_second got=%h wait=%0d exp=%h wait=0", dut_vec, w, e2);
        end
        send(OP_ADD, 8'h7F, 8'h01, 1'b1, 1'b0, w);
        e3 = exp_q.pop_front();
        checks++;
        if (dut_vec !== e3 || w !== 0) begin
            failures++; $display("FAIL bp_third got=%h wait=%0d exp=%h wait=0", dut_vec, w, e3);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_no_dup got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_accumulator();
        logic [12:0] e; int w;
        send(OP_ADD, 8'h05, 8'h03, 1'b0, 1'b0, w);
        e = exp_q.pop_front();
        e = {1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (dut_vec !== e) begin
            failures++; $display("FAIL acc_load got=%h exp=%h", dut_vec, e);
        end
        send(OP_ADD, 8'hEE, 8'h02, 1'b0, 1'b1, w);
        e = exp_q.pop_front();
        e = {1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (dut_vec !== e) begin
            failures++; $display("FAIL acc_add got=%h exp=%h", dut_vec, e);
        end
        send(OP_SLL, 8'h55, 8'h01, 1'b0, 1'b1, w);
        e = exp_q.pop_front();
        e = {1'b1, 8'h14, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (dut_vec !== e) begin
            failures++; $display("FAIL acc_sll got=%h exp=%h", dut_vec, e);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [12:0] e; int w;
        send(OP_ADD, 8'h30, 8'h03, 1'b0, 1'b0, w);
        e = exp_q.pop_front();
        send(OP_MUL, 8'h0F, 8'h0F, 1'b0, 1'b0, w);
        e = exp_q.pop_front();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_acc = 8'h00;
        exp_q.delete();
        checks++;
        if ({busy, dut_vec} !== 14'd0) begin
            failures++; $display("FAIL rst_mid_mul got=%h exp=%h", {busy, dut_vec}, 14'd0);
        end
        send(OP_ADD, 8'h99, 8'h05, 1'b0, 1'b1, w);
        e = exp_q.pop_front();
        e = {1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (dut_vec !== e) begin
            failures++; $display("FAIL rst_acc_cleared got=%h exp=%h", dut_vec, e);
        end
    endtask

    task automatic test_enbl_stall();
        logic [12:0] e; int w, t;
        send(OP_MUL, 8'h0D, 8'h0B, 1'b0, 1'b0, w);
        e = exp_q.pop_front();
        t = 0;
        while (!out_valid && t < 40) begin
            t++;
            enbl = !(t >= 3 && t <= 7);
            @(posedge clk); #1;
            if (!enbl) begin
                checks++;
                if ({in_ready, busy, out_valid} !== 3'b010) begin
                    failures++; $display("FAIL enbl_frozen t=%0d got=%b exp=010", t, {in_ready, busy, out_valid});
                end
            end
        end
        enbl = 1'b1;
        e = {1'b1, 8'h8F, 1'b0, 1'b0, 1'b1, 1'b0};
        checks++;
        if (dut_vec !== e || t !== 13) begin
            failures++; $display("FAIL enbl_stall_mul got=%h lat=%0d exp=%h lat=13", dut_vec, t, e);
        end
    endtask

    task automatic test_random();
        logic [12:0] e, last_e;
        logic [2:0]  op;
        logic [7:0]  x, y;
        logic        ci, as;
        int          w, cyc, stall;
        exp_q.delete();
        for (int n = 0; n < 120; n++) begin
            op = 3'($urandom_range(0, 7));
            x  = 8'($urandom);
            y  = 8'($urandom);
            ci = 1'($urandom);
            as = ($urandom_range(0, 3) == 0);
            send(op, x, y, ci, as, w);
            e = exp_q.pop_front();
            wait_out(cyc);
            checks++;
            if (dut_vec !== e || cyc !== ((op == OP_MUL) ? 8 : 0)) begin
                failures++; $display("FAIL rand_%0d op=%0d got=%h lat=%0d exp=%h", n, op, dut_vec, cyc, e);
            end
            last_e = e;
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'b0;
                stall = $urandom_range(1, 3);
                for (int k = 0; k < stall; k++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (dut_vec !== last_e) begin
                        failures++; $display("FAIL rand_hold_%0d got=%h exp=%h", n, dut_vec, last_e);
                    end
                end
                out_ready = 1'b1;
            end
        end
    endtask

    initial begin
        rst = 1'b1; enbl = 1'b1; a = '0; b = '0; c_in = 1'b0; ALUOp = OP_AND;
        acc_sel = 1'b0; in_valid = 1'b0; out_ready = 1'b1; model_acc = 8'h00;
        test_reset();
        test_add_flags();
        test_sub_slt();
        test_mul();
        test_back_pressure();
        test_accumulator();
        test_reset_mid_mul();
        test_enbl_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
